// File: rtl/psum_out_pkg.sv
// Shared widths, partial-sum format encoding and saturation helper for psum_out_stage.
package psum_out_pkg;

    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned OUT_BW  = 8;

    // Value of the format input
    localparam logic FMT_TWOS    = 1'b0;
    localparam logic FMT_SIGNMAG = 1'b1;

    // Working width of the saturate helper; must exceed psum_bw + 2
    localparam int unsigned SAT_W = 32;

    // Clamp a signed value into the range of a w-bit two's-complement number
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// Synchronous FIFO with occupancy count, registered full/empty flags and synchronous flush.
// rdata is the head entry, forced to zero while empty.
module psum_out_fifo
    import psum_out_pkg::*;
#(
    parameter int unsigned W     = OUT_BW,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push_c;
    logic          do_pop_c;
    logic [CW-1:0] count_nxt_c;

    // Qualify push/pop against flags and compute next occupancy; clr wins
    always_comb begin
        do_pop_c    = pop && !empty && !clr;
        do_push_c   = push && (!full || do_pop_c) && !clr;
        drop_c      = push && full && !do_pop_c && !clr;
        count_nxt_c = count;
        case ({do_push_c, do_pop_c})
            2'b10:   count_nxt_c = count + CW'(1);
            2'b01:   count_nxt_c = count - CW'(1);
            default: count_nxt_c = count;
        endcase
        if (clr) begin
            count_nxt_c = '0;
        end
    end

    // Pointers, occupancy and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (clr) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push_c) wptr <= wptr + AW'(1);
                if (do_pop_c)  rptr <= rptr + AW'(1);
            end
            count <= count_nxt_c;
            full  <= (count_nxt_c == CW'(DEPTH));
            empty <= (count_nxt_c == '0);
        end
    end

    // Storage array; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wptr] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/psum_out_stage.sv
// MAC partial-sum output stage: capture, format normalisation, ReLU, shift,
// saturation and a small valid/ready FIFO toward the output SRAM writer.
// Optional macro PSUM_OUT_ROUND_EN: round half up before the right shift.
module psum_out_stage
    import psum_out_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned out_bw  = OUT_BW,
    parameter int unsigned SHIFT   = 0,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic [psum_bw-1:0]      psum_in,
    input  logic                    psum_vld,
    input  logic                    format,
    input  logic                    relu_en,
    output logic [out_bw-1:0]       o_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    // Conversion width holds +/-(2^(psum_bw-1)) without wrap; extra bit for rounding
    localparam int unsigned VW = psum_bw + 1;
    localparam int unsigned XW = psum_bw + 2;

`ifdef PSUM_OUT_ROUND_EN
    localparam logic [XW-1:0] RND = XW'((SHIFT == 0) ? 0 : (1 << (SHIFT - 1)));
`endif

    logic signed [VW-1:0] conv_c;
    logic signed [VW-1:0] mag_c;
    logic                 s1_vld;
    logic signed [VW-1:0] s1_val;
    logic                 s1_relu;
    logic signed [VW-1:0] relu_c;
    logic signed [XW-1:0] pre_c;
    logic signed [XW-1:0] shr_c;
    logic [out_bw-1:0]    res_c;
    logic                 fifo_empty;
    logic                 fifo_drop_c;

    // Normalise two's-complement or sign-magnitude input to a signed value
    always_comb begin
        mag_c  = $signed({2'b00, psum_in[psum_bw-2:0]});
        conv_c = VW'($signed(psum_in));
        if (format == FMT_SIGNMAG) begin
            conv_c = psum_in[psum_bw-1] ? -mag_c : mag_c;
        end
    end

    // Stage 1: capture the converted partial sum and its ReLU control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_val  <= '0;
            s1_relu <= 1'b0;
        end else if (clr) begin
            s1_vld  <= 1'b0;
        end else begin
            s1_vld <= psum_vld;
            if (psum_vld) begin
                s1_val  <= conv_c;
                s1_relu <= relu_en;
            end
        end
    end

    // ReLU, optional rounding, floor shift and saturation of the stage-1 value
    always_comb begin
        relu_c = (s1_relu && s1_val[VW-1]) ? '0 : s1_val;
        pre_c  = XW'(relu_c);
`ifdef PSUM_OUT_ROUND_EN
        pre_c  = pre_c + $signed(RND);
`endif
        shr_c  = pre_c >>> SHIFT;
        res_c  = out_bw'(saturate(SAT_W'(shr_c), out_bw));
    end

    // Stage 2: result FIFO toward the SRAM writer
    psum_out_fifo #(
        .W     (out_bw),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .push   (s1_vld),
        .wdata  (res_c),
        .pop    (o_ready),
        .rdata  (o_data),
        .count  (count),
        .full   (full),
        .empty  (fifo_empty),
        .drop_c (fifo_drop_c)
    );

    assign o_valid = !fifo_empty;

    // Sticky flag for a result dropped on a full FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (clr) begin
            overflow <= 1'b0;
        end else if (fifo_drop_c) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_out_stage.sv
// Directed bench for psum_out_stage: conversion, saturation, FIFO boundaries,
// clr, async reset, plus a SHIFT=2 instance for shift/rounding.
module tb_psum_out_stage;
    import psum_out_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic [15:0] psum_in;
    logic        psum_vld;
    logic        format;
    logic        relu_en;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_ready;
    logic        full;
    logic [2:0]  count;
    logic        overflow;

    logic [15:0] psum_in2;
    logic        psum_vld2;
    logic        format2;
    logic        relu_en2;
    logic [7:0]  o_data2;
    logic        o_valid2;
    logic        o_ready2;
    logic        full2;
    logic [2:0]  count2;
    logic        overflow2;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PSUM_OUT_ROUND_EN
    localparam logic [7:0] EXP_P6 = 8'h02;
    localparam logic [7:0] EXP_N6 = 8'hFF;
`else
    localparam logic [7:0] EXP_P6 = 8'h01;
    localparam logic [7:0] EXP_N6 = 8'hFE;
`endif

    always #5 clk = ~clk;

    psum_out_stage #(.psum_bw(16), .out_bw(8), .SHIFT(0), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .psum_in  (psum_in),
        .psum_vld (psum_vld),
        .format   (format),
        .relu_en  (relu_en),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    psum_out_stage #(.psum_bw(16), .out_bw(8), .SHIFT(2), .DEPTH(4)) dut_shift (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .psum_in  (psum_in2),
        .psum_vld (psum_vld2),
        .format   (format2),
        .relu_en  (relu_en2),
        .o_data   (o_data2),
        .o_valid  (o_valid2),
        .o_ready  (o_ready2),
        .full     (full2),
        .count    (count2),
        .overflow (overflow2)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One result through an empty FIFO with o_ready=1
    task automatic send_one(input string tag, input logic [15:0] p, input logic fmt,
                            input logic relu, input logic [7:0] exp);
        @(negedge clk);
        psum_in = p; format = fmt; relu_en = relu; psum_vld = 1'b1;
        @(negedge clk);
        psum_vld = 1'b0;
        check({tag, "_lat"}, 16'(o_valid), 16'd0);
        @(negedge clk);
        check({tag, "_vld"}, 16'(o_valid), 16'd1);
        check({tag, "_dat"}, 16'(o_data), 16'(exp));
        @(negedge clk);
    endtask

    // Five back-to-back results base..base+4 with o_ready=0
    task automatic fill5(input logic [15:0] base);
        o_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            psum_in = base + 16'(k); format = FMT_TWOS; relu_en = 1'b0; psum_vld = 1'b1;
        end
        @(negedge clk);
        psum_vld = 1'b0;
        @(negedge clk);
    endtask

    // One value through the SHIFT=2 instance
    task automatic send_shift(input string tag, input logic [15:0] p, input logic [7:0] exp);
        @(negedge clk);
        psum_in2 = p; psum_vld2 = 1'b1;
        @(negedge clk);
        psum_vld2 = 1'b0;
        @(negedge clk);
        check({tag, "_vld"}, 16'(o_valid2), 16'd1);
        check({tag, "_dat"}, 16'(o_data2), 16'(exp));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0;
        psum_in = '0; psum_vld = 1'b0; format = FMT_TWOS; relu_en = 1'b0; o_ready = 1'b1;
        psum_in2 = '0; psum_vld2 = 1'b0; format2 = FMT_TWOS; relu_en2 = 1'b0; o_ready2 = 1'b1;
        #12;
        check("rst_valid", 16'(o_valid), 16'd0);
        check("rst_data",  16'(o_data),  16'd0);
        check("rst_full",  16'(full),    16'd0);
        check("rst_count", 16'(count),   16'd0);
        check("rst_ovf",   16'(overflow), 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Two's complement, saturation
        send_one("tc_100",   16'h0064, FMT_TWOS, 1'b0, 8'h64);
        send_one("tc_400",   16'h0190, FMT_TWOS, 1'b0, 8'h7F);
        send_one("tc_m256",  16'hFF00, FMT_TWOS, 1'b0, 8'h80);
        // Sign-magnitude
        send_one("sm_m5",    16'h8005, FMT_SIGNMAG, 1'b0, 8'hFB);
        send_one("sm_m5_rl", 16'h8005, FMT_SIGNMAG, 1'b1, 8'h00);
        send_one("sm_nzero", 16'h8000, FMT_SIGNMAG, 1'b0, 8'h00);
        send_one("sm_p5",    16'h0005, FMT_SIGNMAG, 1'b0, 8'h05);

        // Overflow on a full FIFO, then drain in order
        fill5(16'd1);
        check("ovf_full",  16'(full),     16'd1);
        check("ovf_count", 16'(count),    16'd4);
        check("ovf_flag",  16'(overflow), 16'd1);
        o_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain_vld%0d", k), 16'(o_valid), 16'd1);
            check($sformatf("drain_dat%0d", k), 16'(o_data),  16'(k));
            @(negedge clk);
        end
        check("drain_empty", 16'(o_valid),  16'd0);
        check("ovf_sticky",  16'(overflow), 16'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_ovf",   16'(overflow), 16'd0);
        check("clr_count", 16'(count),    16'd0);

        // Push on a full FIFO with a simultaneous pop
        o_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            psum_in = 16'd10 + 16'(k); psum_vld = 1'b1;
        end
        @(negedge clk);
        psum_vld = 1'b0;
        @(negedge clk);
        check("pp_full0", 16'(full),  16'd1);
        check("pp_cnt0",  16'(count), 16'd4);
        psum_in = 16'd14; psum_vld = 1'b1;
        @(negedge clk);
        psum_vld = 1'b0; o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        check("pp_cnt",  16'(count),    16'd4);
        check("pp_full", 16'(full),     16'd1);
        check("pp_ovf",  16'(overflow), 16'd0);
        o_ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            check($sformatf("pp_dat%0d", k), 16'(o_data), 16'(k));
            @(negedge clk);
        end
        check("pp_empty", 16'(o_valid), 16'd0);

        // clr with a psum_vld in the same cycle, another result in stage 1
        o_ready = 1'b0;
        @(negedge clk);
        psum_in = 16'd20; psum_vld = 1'b1;
        @(negedge clk);
        psum_in = 16'd21; clr = 1'b1;
        @(negedge clk);
        psum_vld = 1'b0; clr = 1'b0;
        check("clr2_count", 16'(count),    16'd0);
        check("clr2_valid", 16'(o_valid),  16'd0);
        check("clr2_ovf",   16'(overflow), 16'd0);
        @(negedge clk);
        @(negedge clk);
        check("clr2_none", 16'(o_valid), 16'd0);

        // SHIFT=2 instance: floor or round-half-up
        send_shift("sh_p6", 16'd6,    EXP_P6);
        send_shift("sh_n6", 16'hFFFA, EXP_N6);

        // Asynchronous reset between edges
        fill5(16'd30);
        check("ar_pre_ovf", 16'(overflow), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 16'(o_valid),  16'd0);
        check("ar_data",  16'(o_data),   16'd0);
        check("ar_full",  16'(full),     16'd0);
        check("ar_count", 16'(count),    16'd0);
        check("ar_ovf",   16'(overflow), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ar_post_valid", 16'(o_valid), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
